// File: rtl/mips_data_memory_pkg.sv
// ============================================================================
// Module : mips_data_memory_pkg
// Brief  : Datapath-wide widths shared by data memory, register file and ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_data_memory_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int IDX_W  = $clog2(DEPTH);
endpackage

`default_nettype wire

// File: rtl/mips_data_memory.sv
// ============================================================================
// Module : mips_data_memory
// Brief  : Word-addressed data memory, combinational read, clocked write.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_data_memory
  import mips_data_memory_pkg::*;
#(
  parameter int DATA_W = mips_data_memory_pkg::DATA_W,
  parameter int ADDR_W = mips_data_memory_pkg::ADDR_W,
  parameter int DEPTH  = mips_data_memory_pkg::DEPTH
) (
  output logic [DATA_W-1:0] read_data,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              sig_mem_read,
  input  logic              sig_mem_write,
  input  logic              clk,
  input  logic              rst
);

  // Index width follows this instance's DEPTH, which may differ from the package default.
  localparam int LOC_IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [LOC_IDX_W-1:0] idx;
  logic                 in_range;

  assign idx = mem_address[LOC_IDX_W-1:0];

  generate
    if (ADDR_W > LOC_IDX_W) begin : g_range_check
      assign in_range = ~|mem_address[ADDR_W-1:LOC_IDX_W];
    end else begin : g_range_full
      assign in_range = 1'b1;
    end
  endgenerate

  // Reset wins over a coincident write, so that write is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sig_mem_write && in_range) begin
      mem[idx] <= write_data;
    end
  end

  always_comb begin
    read_data = '0;
    if (sig_mem_read && in_range) begin
      read_data = mem[idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_data_memory.sv
// ============================================================================
// Module : tb_mips_data_memory
// Brief  : Self-checking bench with directed and random accesses vs. a model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_data_memory;

  logic [31:0] read_data;
  logic [31:0] mem_address;
  logic [31:0] write_data;
  logic        sig_mem_read;
  logic        sig_mem_write;
  logic        clk;
  logic        rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [256];

  mips_data_memory dut (
    .read_data    (read_data),
    .mem_address  (mem_address),
    .write_data   (write_data),
    .sig_mem_read (sig_mem_read),
    .sig_mem_write(sig_mem_write),
    .clk          (clk),
    .rst          (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic rd, input logic [31:0] a);
    if (rd && a < 32'd256) return model[a[7:0]];
    return 32'd0;
  endfunction

  // One processor cycle: check the read before the edge, apply the model, check after.
  task automatic step(input string tag, input logic rs, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d);
    rst = rs; sig_mem_read = rd; sig_mem_write = wr; mem_address = a; write_data = d;
    #1;
    check({tag, "_pre"}, read_data, exp_read(rd, a));
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 256; i++) model[i] = 32'd0;
    end else if (wr && a < 32'd256) begin
      model[a[7:0]] = d;
    end
    #1;
    check({tag, "_post"}, read_data, exp_read(rd, a));
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rst = 1'b0; sig_mem_read = 1'b1; sig_mem_write = 1'b0; mem_address = a;
    #1;
    check(tag, read_data, exp);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b0; sig_mem_read = 1'b0; sig_mem_write = 1'b0;
    mem_address = '0; write_data = '0;
    @(posedge clk); #1;

    step("reset", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    peek("rst_rd0", 32'd0, 32'd0);
    peek("rst_rd3", 32'd3, 32'd0);
    step("rd_off", 1'b0, 1'b0, 1'b0, 32'd3, 32'd0);

    step("wr1", 1'b0, 1'b0, 1'b1, 32'd1, 32'd8);
    peek("rd1", 32'd1, 32'd8);
    peek("rd0", 32'd0, 32'd0);

    step("wr12", 1'b0, 1'b0, 1'b1, 32'd12, 32'd13);
    step("wr255", 1'b0, 1'b0, 1'b1, 32'd255, 32'hFFFF_FFFF);
    peek("rd12", 32'd12, 32'd13);
    peek("rd255", 32'd255, 32'hFFFF_FFFF);

    step("wr256", 1'b0, 1'b0, 1'b1, 32'd256, 32'd5);
    peek("rd256", 32'd256, 32'd0);
    peek("rd0_oor", 32'd0, 32'd0);
    peek("rd255_oor", 32'd255, 32'hFFFF_FFFF);

    rst = 1'b0; sig_mem_read = 1'b1; sig_mem_write = 1'b1;
    mem_address = 32'd1; write_data = 32'd9;
    #1;
    check("rw_old", read_data, 32'd8);
    @(posedge clk); #1;
    check("rw_new", read_data, 32'd9);
    model[1] = 32'd9;

    step("rst_wr", 1'b1, 1'b0, 1'b1, 32'd2, 32'd7);
    peek("rd2_rst", 32'd2, 32'd0);
    peek("rd1_rst", 32'd1, 32'd0);
    peek("rd12_rst", 32'd12, 32'd0);
    peek("rd255_rst", 32'd255, 32'd0);

    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
